// File: rtl/sig_change_logger_if.sv
// sig_change_logger_if
// Record stream carrying change records out of the logger.
//   evt_valid : record present on evt_data (source -> sink)
//   evt_ready : sink accepts the record when evt_valid is also high
//   evt_data  : {ovf, ts, mask, value}, REC_W bits
// master = record source (the logger), slave = record consumer.
interface sig_change_logger_if #(
  parameter int REC_W = 23
);
  logic             evt_valid;
  logic             evt_ready;
  logic [REC_W-1:0] evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );
endinterface

// File: rtl/sig_change_logger.sv
// sig_change_logger
// Watches NUM_CH synchronous inputs and, whenever any of them changes while
// capture is enabled, queues one timestamped record {ovf, ts, mask, value}
// into a DEPTH-entry FIFO that drains over a valid/ready stream.
// Ports:
//   clk        : system clock, rising edge
//   reset_     : synchronous reset, active low
//   i_en       : capture enable (changes are still tracked when low)
//   i_sig      : monitored signals, already synchronous to clk
//   evt        : record stream (master side): evt_valid/evt_data out, evt_ready in
//   o_level    : FIFO occupancy, 0..DEPTH
//   o_drop_cnt : saturating count of records lost to a full FIFO
module sig_change_logger #(
  parameter  int NUM_CH = 3,
  parameter  int TS_W   = 16,
  parameter  int DEPTH  = 8,
  parameter  int DROP_W = 8,
  localparam int REC_W  = 1 + TS_W + 2 * NUM_CH,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                i_en,
  input  logic [NUM_CH-1:0]   i_sig,
  sig_change_logger_if.master evt,
  output logic [LW-1:0]       o_level,
  output logic [DROP_W-1:0]   o_drop_cnt
);

  logic [TS_W-1:0]   r_ts;
  logic              r_primed;
  logic [NUM_CH-1:0] r_sig_q;
  logic              r_ovf_pend;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [REC_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_out_valid;
  logic [REC_W-1:0]  r_out_data;

  logic [NUM_CH-1:0] w_chg;
  logic              w_pop;
  logic              w_push_req;
  logic              w_full;
  logic              w_accept;
  logic              w_drop;
  logic [REC_W-1:0]  w_rec;
  logic [AW-1:0]     w_rd_next;
  logic [LW-1:0]     w_level_rd;
  logic [LW-1:0]     w_level_next;

  assign w_chg      = i_sig ^ r_sig_q;
  assign w_pop      = r_out_valid && evt.evt_ready;
  assign w_push_req = r_primed && i_en && (w_chg != '0);
  assign w_full     = (r_level == LW'(DEPTH));
  // A full FIFO still takes a record when the head leaves on the same edge.
  assign w_accept   = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_accept;
  assign w_rec      = {r_ovf_pend, r_ts, w_chg, i_sig};

  // Occupancy after this edge's pop but before its push: the output register
  // is reloaded from this, so a freshly written record is never bypassed and
  // shows up one edge later.
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  assign w_level_rd   = r_level - LW'(w_pop);
  assign w_level_next = w_level_rd + LW'(w_accept);

  // Storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (reset_ && w_accept) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_ts        <= '0;
      r_primed    <= 1'b0;
      r_sig_q     <= '0;
      r_ovf_pend  <= 1'b0;
      r_drop_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_primed <= 1'b1;
      r_sig_q  <= i_sig;

      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_ovf_pend <= 1'b0;
      end else if (w_drop) begin
        r_ovf_pend <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
      end

      r_rd_ptr    <= w_rd_next;
      r_level     <= w_level_next;
      r_out_valid <= (w_level_rd != '0);
      r_out_data  <= (w_level_rd != '0) ? r_mem[w_rd_next] : '0;
    end
  end

  assign evt.evt_valid = r_out_valid;
  assign evt.evt_data  = r_out_data;
  assign o_level       = r_level;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_sig_change_logger.sv
// tb_sig_change_logger
// Drives two loggers (TS_W=16 and TS_W=4, otherwise default) with identical
// stimulus and checks both against one queue-based reference model, plus a
// directed vector table and hand-written corner-case sequences.
module tb_sig_change_logger;
  localparam int DEPTH = 8;
  localparam int RW16  = 23;
  localparam int RW4   = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst;
  logic       d_en;
  logic       d_rdy;
  logic [2:0] d_sig;
  logic [3:0] lvl16, lvl4;
  logic [7:0] drop16, drop4;

  sig_change_logger_if #(.REC_W(RW16)) if16 ();
  sig_change_logger_if #(.REC_W(RW4))  if4 ();
  assign if16.evt_ready = d_rdy;
  assign if4.evt_ready  = d_rdy;

  sig_change_logger #(.NUM_CH(3), .TS_W(16), .DEPTH(DEPTH), .DROP_W(8)) dut16 (
    .clk(clk), .reset_(d_rst), .i_en(d_en), .i_sig(d_sig),
    .evt(if16), .o_level(lvl16), .o_drop_cnt(drop16)
  );

  sig_change_logger #(.NUM_CH(3), .TS_W(4), .DEPTH(DEPTH), .DROP_W(8)) dut4 (
    .clk(clk), .reset_(d_rst), .i_en(d_en), .i_sig(d_sig),
    .evt(if4), .o_level(lvl4), .o_drop_cnt(drop4)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        ovf;
    int unsigned ts;
    logic [2:0]  mask;
    logic [2:0]  val;
    int unsigned pe;   // edge number at which the record was logged
  } rec_t;

  rec_t        mq[$];
  int unsigned m_ts, m_edge, m_drop;
  bit          m_primed, m_ovf, m_vis;
  logic [2:0]  m_sigq;

  function automatic logic [RW16-1:0] exp16(input rec_t r);
    logic [15:0] t;
    t = r.ts[15:0];
    return {r.ovf, t, r.mask, r.val};
  endfunction

  function automatic logic [RW4-1:0] exp4(input rec_t r);
    logic [3:0] t;
    t = r.ts[3:0];
    return {r.ovf, t, r.mask, r.val};
  endfunction

  task automatic model_edge();
    logic [2:0] chg;
    rec_t       r;
    m_edge++;
    if (!d_rst) begin
      mq.delete();
      m_ts = 0; m_primed = 0; m_sigq = '0; m_drop = 0; m_ovf = 0; m_vis = 0;
    end else begin
      if (m_vis && d_rdy) void'(mq.pop_front());
      if (!m_primed) begin
        m_primed = 1;
      end else begin
        chg = d_sig ^ m_sigq;
        if (d_en && chg != 3'b000) begin
          if (mq.size() < DEPTH) begin
            r.ovf = m_ovf; r.ts = m_ts; r.mask = chg; r.val = d_sig; r.pe = m_edge;
            mq.push_back(r);
            m_ovf = 0;
          end else begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1;
          end
        end
      end
      m_sigq = d_sig;
      m_ts++;
      // A record becomes visible one edge after it was logged, once at head.
      m_vis = (mq.size() > 0) && (mq[0].pe < m_edge);
    end
  endtask

  task automatic compare_all();
    chk("valid16", if16.evt_valid, m_vis);
    chk("level16", lvl16, mq.size());
    chk("drop16",  drop16, m_drop);
    if (m_vis) chk("data16", if16.evt_data, exp16(mq[0]));
    chk("valid4", if4.evt_valid, m_vis);
    chk("level4", lvl4, mq.size());
    chk("drop4",  drop4, m_drop);
    if (m_vis) chk("data4", if4.evt_data, exp4(mq[0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    d_rst = 1'b0;
    cyc();
    d_rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst;
    logic            en;
    logic [2:0]      sig;
    logic            rdy;
    logic            ev;
    logic [3:0]      el;
    logic [RW16-1:0] ed;
  } vec_t;

  vec_t vt[20];

  initial begin
    logic [RW16-1:0] ra, rb, rc;
    ra = {1'b0, 16'd10, 3'b001, 3'b001};
    rb = {1'b0, 16'd12, 3'b111, 3'b110};
    rc = {1'b0, 16'd15, 3'b100, 3'b011};

    vt[0] = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, '0};
    for (int i = 1; i <= 10; i++) vt[i] = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, '0};
    vt[11] = '{1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 4'd1, '0};
    vt[12] = '{1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 4'd1, ra};
    vt[13] = '{1'b1, 1'b1, 3'b110, 1'b1, 1'b0, 4'd1, '0};
    vt[14] = '{1'b1, 1'b1, 3'b110, 1'b1, 1'b1, 4'd1, rb};
    vt[15] = '{1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 4'd0, '0};
    vt[16] = '{1'b1, 1'b1, 3'b011, 1'b1, 1'b0, 4'd1, '0};
    vt[17] = '{1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 4'd1, rc};
    vt[18] = '{1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 4'd1, rc};
    vt[19] = '{1'b1, 1'b1, 3'b011, 1'b1, 1'b0, 4'd0, '0};

    d_rst = 1'b0; d_en = 1'b1; d_sig = 3'b000; d_rdy = 1'b0;

    // Quiet inputs after reset: nothing is ever logged.
    do_reset();
    repeat (20) cyc();
    chk("quiet_valid", if16.evt_valid, 1'b0);
    chk("quiet_level", lvl16, 4'd0);
    chk("quiet_drop",  drop16, 8'd0);

    // Table: prime, single toggle at ts=10, multi-channel change, en=0 gap.
    foreach (vt[i]) begin
      d_rst = vt[i].rst; d_en = vt[i].en; d_sig = vt[i].sig; d_rdy = vt[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_valid", i), if16.evt_valid, vt[i].ev);
      chk($sformatf("tbl%0d_level", i), lvl16, vt[i].el);
      if (vt[i].ev) chk($sformatf("tbl%0d_data", i), if16.evt_data, vt[i].ed);
    end

    // Overflow: 11 changes into an 8-deep FIFO with no consumer.
    d_en = 1'b1; d_sig = 3'b000; d_rdy = 1'b0;
    do_reset();
    cyc();
    for (int i = 0; i < 11; i++) begin
      d_sig[0] = ~d_sig[0];
      cyc();
    end
    chk("ovf_level", lvl16, 4'd8);
    chk("ovf_drop",  drop16, 8'd3);
    d_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_ovf", i), if16.evt_data[RW16-1], 1'b0);
      cyc();
    end
    chk("drained_level", lvl16, 4'd0);
    d_sig[1] = ~d_sig[1];
    cyc();
    cyc();
    chk("after_drop_valid", if16.evt_valid, 1'b1);
    chk("after_drop_ovf",   if16.evt_data[RW16-1], 1'b1);
    d_sig[1] = ~d_sig[1];
    cyc();
    cyc();
    chk("next_valid", if16.evt_valid, 1'b1);
    chk("next_ovf",   if16.evt_data[RW16-1], 1'b0);

    // Full FIFO with simultaneous push and pop: no drop, level holds.
    d_rdy = 1'b0; d_sig = 3'b000;
    do_reset();
    cyc();
    for (int i = 0; i < 8; i++) begin
      d_sig[2] = ~d_sig[2];
      cyc();
    end
    chk("full_level", lvl16, 4'd8);
    d_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_sig[0] = ~d_sig[0];
      cyc();
      chk($sformatf("full_pp%0d_level", i), lvl16, 4'd8);
      chk($sformatf("full_pp%0d_drop", i),  drop16, 8'd0);
    end
    repeat (10) cyc();

    // Drop counter saturation.
    d_rdy = 1'b0; d_sig = 3'b000;
    do_reset();
    cyc();
    for (int i = 0; i < 270; i++) begin
      d_sig[0] = ~d_sig[0];
      cyc();
    end
    chk("drop_sat", drop16, 8'd255);

    // Timestamp wrap on the 4-bit instance: ts 14 then 18 -> 2.
    d_rdy = 1'b1; d_sig = 3'b000;
    do_reset();
    repeat (14) cyc();
    d_sig = 3'b001;
    cyc();
    cyc();
    chk("wrap_a_valid", if4.evt_valid, 1'b1);
    chk("wrap_a_ts", if4.evt_data[9:6], 4'd14);
    cyc();
    cyc();
    d_sig = 3'b000;
    cyc();
    cyc();
    chk("wrap_b_ts4",  if4.evt_data[9:6], 4'd2);
    chk("wrap_b_ts16", if16.evt_data[21:6], 16'd18);

    // Reset while records are pending.
    d_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_sig[1] = ~d_sig[1];
      cyc();
    end
    d_rdy = 1'b1;
    cyc();
    d_rst = 1'b0;
    cyc();
    chk("rst_mid_valid", if16.evt_valid, 1'b0);
    chk("rst_mid_level", lvl16, 4'd0);
    d_rst = 1'b1;
    repeat (3) cyc();
    d_sig[2] = ~d_sig[2];
    cyc();
    cyc();
    chk("reprime_valid", if16.evt_valid, 1'b1);
    chk("reprime_ts", if16.evt_data[21:6], 16'd3);

    // Randomised traffic against the model.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 90 : 50);
      for (int i = 0; i < 200; i++) begin
        d_en  = ($urandom_range(0, 9) < 8);
        d_rdy = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 2) == 0) d_sig = d_sig ^ 3'($urandom_range(1, 7));
        d_rst = ($urandom_range(0, 399) != 0);
        cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sig_change_logger.md
Name: sig_change_logger

Overview:
Parametrised multi-channel signal-change monitor: the synthesizable successor of the bench-side LED change display. Samples NUM_CH synchronous inputs every cycle. On any change, captures a timestamped record (values plus changed-channel mask) into an internal FIFO. Records drain over a valid/ready stream, typically to the JTAG UART transmit path.

Parameters:
NUM_CH, 3, number of monitored channels (1..32)
TS_W, 16, timestamp counter width in bits (4..32)
DEPTH, 8, FIFO depth in records; power of 2, >=2
DROP_W, 8, width of saturating dropped-event counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset_  in  1  synchronous reset, active-low
en  in  1  capture enable; when 0, changes are tracked but not logged
sig  in  NUM_CH  monitored signals, already synchronous to clk
evt_valid  out  1  record available at evt_data
evt_ready  in  1  consumer accepts record when evt_valid && evt_ready
evt_data  out  REC_W  record = {ovf, ts[TS_W-1:0], mask[NUM_CH-1:0], value[NUM_CH-1:0]}; REC_W = 1+TS_W+2*NUM_CH
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
drop_cnt  out  DROP_W  count of events lost to full FIFO, saturating

Behaviour:
- Reset (reset_=0 at a rising edge) forces:
  - ts=0, primed=0, sig_q=0, FIFO empty.
  - evt_valid=0, evt_data=0, level=0, drop_cnt=0, ovf_pend=0.
- Reset mid-operation discards all FIFO contents; no partial record survives.
- Timestamp: ts increments by 1 every cycle from 0 after reset; wraps modulo 2^TS_W with no marker.
- Priming:
  - First edge after reset release: sig_q<=sig, primed<=1, no event regardless of en.
  - Avoids a spurious event from the reset value.
- Detection, at each edge with primed=1:
  - chg = sig ^ sig_q; sig_q<=sig always, independent of en.
  - If en=1 and chg!=0: push record {ovf_pend, ts, chg, sig}, where ts is the value before this edge's increment.
  - Multiple channels changing in one cycle produce ONE record with several mask bits set.
- Push acceptance: accepted if level<DEPTH, or if level==DEPTH and a pop occurs at the same edge (simultaneous push+pop when full is legal; level unchanged).
- Drop: push not accepted:
  - Record discarded, drop_cnt increments and saturates at 2^DROP_W-1, ovf_pend<=1.
  - Next accepted record carries ovf=1; ovf_pend clears on that same edge.
  - If a drop and an accepted push occur together (impossible by construction), ignore.
- Pop: evt_valid && evt_ready at edge → head advances.
- evt_data/evt_valid are registered FIFO head outputs and stay stable while evt_valid=1 and evt_ready=0.
- Latency: change visible on sig before edge k → record pushed at edge k → evt_valid=1 after edge k+1 if FIFO was empty (2-cycle latency). Throughput one record per cycle.
- Empty push+pop: no bypass; record appears per latency above.
- level updates at the same edge as push/pop: +1 push only, -1 pop only, unchanged for both or neither.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty derived from level.
- evt_ready while evt_valid=0: ignored.

Test Plan:
- Reset then sig=3'b000 held, en=1, 20 cycles → evt_valid stays 0, level=0, drop_cnt=0.
- Prime then single toggle: sig 000→001 at edge where ts=10 → one record ovf=0, ts=10, mask=001, value=001; evt_valid rises 2 cycles after the change.
- Simultaneous change 001→110 with evt_ready=1 → one record mask=111, value=110. en=0 then toggle sig → no record, but next change with en=1 uses mask relative to latest sig.
- Overflow: evt_ready=0, DEPTH=8, toggle sig[0] every cycle 11 times:
  - level=8, drop_cnt=3.
  - Release ready, drain 8 records with ovf=0.
  - Next change yields ovf=1; the one after yields ovf=0.
- Full with simultaneous push+pop: level=8, evt_ready=1, change present → no drop, level stays 8, record order preserved.
- Timestamp wrap with TS_W=4: changes at cycles 14 and 18 after reset → ts fields 14 then 2. Assert reset_ mid-drain → evt_valid=0, level=0 next cycle. First change after re-priming logs ts from fresh count.
